// File: rtl/refresh_fsm.sv
// DDR refresh sequencer: tracks refresh debt against tREFI and issues
// PREA -> REF (x pending) with tRP/tRFC spacing when the controller hands over.
module refresh_fsm #(
    parameter int T_REFI   = 6240,
    parameter int T_ALMOST = 64,
    parameter int T_RP     = 16,
    parameter int T_RFC    = 280,
    parameter int MAX_PEND = 8
) (
    input  logic CK_t,
    input  logic reset_n,
    input  logic clear_refresh,
    input  logic refresh_go,
    output logic refresh_almost,
    output logic refresh_done,
    output logic refresh_active,
    output logic refresh_overflow,
    output logic cs_n,
    output logic act_n,
    output logic ras_n,
    output logic cas_n,
    output logic we_n,
    output logic a10
);

    localparam int IW = $clog2(T_REFI);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int WW = $clog2(T_RFC);

    localparam logic [IW-1:0] REFI_LAST = IW'(T_REFI - 1);
    localparam logic [IW-1:0] ALMOST_AT = IW'(T_REFI - T_ALMOST);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);
    localparam logic [WW-1:0] TRP_LOAD  = WW'(T_RP - 2);
    localparam logic [WW-1:0] TRFC_LOAD = WW'(T_RFC - 2);

    // {cs_n, act_n, ras_n, cas_n, we_n, a10}
    localparam logic [5:0] CMD_DES  = 6'b111110;
    localparam logic [5:0] CMD_PREA = 6'b010101;
    localparam logic [5:0] CMD_REF  = 6'b010010;

    typedef enum logic [2:0] {
        RF_IDLE,
        RF_PRE,
        RF_TRP,
        RF_REF,
        RF_TRFC,
        RF_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   interval_cnt;
    logic [IW-1:0]   interval_nxt;
    logic [PW-1:0]   pend_cnt;
    logic [PW-1:0]   pend_nxt;
    logic [WW-1:0]   wait_cnt;
    logic            overflow_nxt;
    logic            almost_nxt;
    logic            wrap;
    logic            ref_now;

    // A REF with nothing pending pays for the current interval, so it restarts
    // the interval and absorbs a wrap landing on the same edge.
    always_comb begin
        wrap         = (interval_cnt == REFI_LAST);
        ref_now      = (state == RF_REF);
        interval_nxt = wrap ? '0 : interval_cnt + 1'b1;
        pend_nxt     = pend_cnt;
        overflow_nxt = refresh_overflow;
        if (clear_refresh) begin
            interval_nxt = '0;
            pend_nxt     = '0;
        end else if (ref_now) begin
            if (pend_cnt == '0) begin
                interval_nxt = '0;
            end else if (!wrap) begin
                pend_nxt = pend_cnt - 1'b1;
            end
        end else if (wrap) begin
            if (pend_cnt == PEND_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 1'b1;
            end
        end
        almost_nxt = (pend_nxt != '0) || (interval_nxt >= ALMOST_AT);
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RF_IDLE;
            interval_cnt     <= '0;
            pend_cnt         <= '0;
            wait_cnt         <= '0;
            refresh_almost   <= 1'b0;
            refresh_done     <= 1'b0;
            refresh_active   <= 1'b0;
            refresh_overflow <= 1'b0;
            {cs_n, act_n, ras_n, cas_n, we_n, a10} <= CMD_DES;
        end else begin
            interval_cnt     <= interval_nxt;
            pend_cnt         <= pend_nxt;
            refresh_overflow <= overflow_nxt;
            refresh_almost   <= almost_nxt;
            refresh_done     <= 1'b0;
            {cs_n, act_n, ras_n, cas_n, we_n, a10} <= CMD_DES;
            case (state)
                RF_IDLE: begin
                    if (refresh_go) begin
                        state          <= RF_PRE;
                        refresh_active <= 1'b1;
                        {cs_n, act_n, ras_n, cas_n, we_n, a10} <= CMD_PREA;
                    end
                end
                RF_PRE: begin
                    state    <= RF_TRP;
                    wait_cnt <= TRP_LOAD;
                end
                RF_TRP: begin
                    if (wait_cnt == '0) begin
                        state <= RF_REF;
                        {cs_n, act_n, ras_n, cas_n, we_n, a10} <= CMD_REF;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RF_REF: begin
                    state    <= RF_TRFC;
                    wait_cnt <= TRFC_LOAD;
                end
                RF_TRFC: begin
                    if (wait_cnt == '0) begin
                        if (pend_cnt != '0) begin
                            state <= RF_REF;
                            {cs_n, act_n, ras_n, cas_n, we_n, a10} <= CMD_REF;
                        end else begin
                            state        <= RF_DONE;
                            refresh_done <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RF_DONE: begin
                    state          <= RF_IDLE;
                    refresh_active <= 1'b0;
                end
                default: begin
                    state          <= RF_IDLE;
                    refresh_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refresh_fsm.sv
// Bench for refresh_fsm: directed scenarios plus random go/clear/reset traffic,
// every cycle compared against a time-stamped reference model of the sequence.
module tb_refresh_fsm;

    localparam int T_REFI   = 100;
    localparam int T_ALMOST = 10;
    localparam int T_RP     = 4;
    localparam int T_RFC    = 20;
    localparam int MAX_PEND = 8;

    localparam logic [5:0] CMD_DES   = 6'b111110;
    localparam logic [5:0] CMD_PREA  = 6'b010101;
    localparam logic [5:0] CMD_REFC  = 6'b010010;
    localparam logic [9:0] RESET_VEC = {4'b0000, CMD_DES};

    logic CK_t = 1'b0;
    logic reset_n = 1'b0;
    logic clear_refresh = 1'b0;
    logic refresh_go = 1'b0;
    logic refresh_almost, refresh_done, refresh_active, refresh_overflow;
    logic cs_n, act_n, ras_n, cas_n, we_n, a10;

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: counters plus absolute cycle stamps of upcoming commands.
    int     m_icnt, m_pend;
    bit     m_ovf, m_almost, m_busy;
    longint cyc = 0;
    longint m_prea, m_ref, m_last, m_done;

    refresh_fsm #(
        .T_REFI(T_REFI), .T_ALMOST(T_ALMOST), .T_RP(T_RP),
        .T_RFC(T_RFC), .MAX_PEND(MAX_PEND)
    ) dut (
        .CK_t(CK_t), .reset_n(reset_n), .clear_refresh(clear_refresh),
        .refresh_go(refresh_go), .refresh_almost(refresh_almost),
        .refresh_done(refresh_done), .refresh_active(refresh_active),
        .refresh_overflow(refresh_overflow), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .a10(a10)
    );

    always #5 CK_t = ~CK_t;

    task automatic model_reset();
        m_icnt = 0; m_pend = 0; m_ovf = 0; m_almost = 0; m_busy = 0;
        m_prea = -1; m_ref = -1; m_last = -1; m_done = -1;
    endtask

    task automatic model_edge(input bit go, input bit clr);
        bit wrap, ref_now;
        int pend_old;
        pend_old = m_pend;
        ref_now  = m_busy && (cyc == m_ref);
        wrap     = (m_icnt == T_REFI - 1);
        if (!m_busy) begin
            if (go) begin
                m_busy = 1; m_prea = cyc + 1; m_ref = cyc + 1 + T_RP;
                m_last = -1; m_done = -1;
            end
        end else if (cyc == m_done) begin
            m_busy = 0;
        end else if (ref_now) begin
            m_last = cyc;
        end else if (m_last >= 0 && cyc == m_last + T_RFC - 1) begin
            if (pend_old > 0) m_ref = cyc + 1;
            else m_done = cyc + 1;
        end
        m_icnt = wrap ? 0 : m_icnt + 1;
        if (clr) begin
            m_icnt = 0; m_pend = 0;
        end else if (ref_now) begin
            if (pend_old == 0) m_icnt = 0;
            else if (!wrap) m_pend = m_pend - 1;
        end else if (wrap) begin
            if (m_pend == MAX_PEND) m_ovf = 1;
            else m_pend = m_pend + 1;
        end
        m_almost = (m_pend > 0) || (m_icnt >= T_REFI - T_ALMOST);
        cyc++;
    endtask

    function automatic logic [9:0] exp_vec();
        logic [5:0] cmd;
        cmd = CMD_DES;
        if (m_busy && cyc == m_prea) cmd = CMD_PREA;
        else if (m_busy && cyc == m_ref) cmd = CMD_REFC;
        return {m_almost, (m_busy && cyc == m_done), m_busy, m_ovf, cmd};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {refresh_almost, refresh_done, refresh_active, refresh_overflow,
                cs_n, act_n, ras_n, cas_n, we_n, a10};
    endfunction

    task automatic chk_vec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit go, input bit clr);
        refresh_go = go;
        clear_refresh = clr;
        @(posedge CK_t);
        if (reset_n) model_edge(go, clr);
        else begin
            model_reset();
            cyc++;
        end
        #1;
        chk_vec("cycle", obs_vec(), exp_vec());
        refresh_go = 1'b0;
        clear_refresh = 1'b0;
    endtask

    task automatic async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_vec("async_reset", obs_vec(), RESET_VEC);
        step(0, 0);
        step(0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int go_div;
        bit saw_done;
        model_reset();

        // Power-up reset and the almost threshold at interval 90.
        step(0, 0);
        step(0, 0);
        chk_vec("reset_state", obs_vec(), RESET_VEC);
        reset_n = 1'b1;
        repeat (89) step(0, 0);
        chk_bit("almost_before_90", refresh_almost, 1'b0);
        step(0, 0);
        chk_bit("almost_at_90", refresh_almost, 1'b1);
        repeat (2) step(0, 0);

        // Pulled-in refresh at interval 92.
        step(1, 0);
        chk_vec("prea_k", obs_vec(), {4'b1010, CMD_PREA});
        for (int i = 1; i <= 24; i++) begin
            step(0, 0);
            if (i == 4) chk_vec("ref_k4", {4'b0000, cs_n, act_n, ras_n, cas_n, we_n, a10}, {4'b0000, CMD_REFC});
            if (i == 5) chk_bit("almost_after_pullin", refresh_almost, 1'b0);
            if (i == 24) chk_bit("done_k24", refresh_done, 1'b1);
        end
        step(0, 0);
        chk_bit("idle_after_done", refresh_active, 1'b0);

        // Three postponed refreshes drained in one sequence.
        async_reset();
        repeat (300) step(0, 0);
        chk_bit("almost_pend3", refresh_almost, 1'b1);
        step(1, 0);
        for (int i = 1; i <= 64; i++) begin
            step(0, 0);
            if (i == 4 || i == 24 || i == 44)
                chk_vec("ref_burst", {4'b0000, cs_n, act_n, ras_n, cas_n, we_n, a10}, {4'b0000, CMD_REFC});
            if (i == 64) begin
                chk_bit("done_k64", refresh_done, 1'b1);
                chk_bit("almost_drained", refresh_almost, 1'b0);
            end
        end

        // Overflow on the ninth unserviced wrap; sticky through clear.
        async_reset();
        repeat (899) step(0, 0);
        chk_bit("ovf_before_9th", refresh_overflow, 1'b0);
        step(0, 0);
        chk_bit("ovf_at_9th", refresh_overflow, 1'b1);
        repeat (50) step(0, 0);
        step(0, 1);
        chk_bit("ovf_after_clear", refresh_overflow, 1'b1);
        chk_bit("almost_after_clear", refresh_almost, 1'b0);

        // Reset during tRFC aborts without a clock edge.
        async_reset();
        chk_bit("ovf_cleared_by_reset", refresh_overflow, 1'b0);
        step(1, 0);
        repeat (14) step(0, 0);
        chk_bit("in_trfc_active", refresh_active, 1'b1);
        async_reset();
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0);
            if (refresh_done) saw_done = 1;
        end
        chk_bit("no_done_after_abort", saw_done, 1'b0);

        // Wrap on the REF edge with two pending.
        async_reset();
        repeat (294) step(0, 0);
        step(1, 0);
        for (int i = 1; i <= 64; i++) begin
            step(0, 0);
            if (i == 4 || i == 24 || i == 44)
                chk_vec("ref_wrap", {4'b0000, cs_n, act_n, ras_n, cas_n, we_n, a10}, {4'b0000, CMD_REFC});
            if (i == 64) chk_bit("done_wrap", refresh_done, 1'b1);
        end

        // Random traffic against the model.
        async_reset();
        go_div = 20;
        for (int i = 0; i < 12000; i++) begin
            if (i % 3000 == 0) begin
                case (i / 3000)
                    0: go_div = 20;
                    1: go_div = 4000;
                    2: go_div = 200;
                    default: go_div = 3;
                endcase
            end
            if ($urandom_range(0, 3999) == 0) async_reset();
            else step($urandom_range(0, go_div) == 0, $urandom_range(0, 899) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/refresh_fsm.md
REFRESH_FSM -- requirements
Module: refresh_fsm

Interface
REQ-001 T_REFI, 6240, refresh interval in CK_t cycles.
REQ-002 T_ALMOST, 64, cycles before interval end at which refresh_almost rises.
REQ-003 T_RP, 16, PREA-to-REF spacing in cycles.
REQ-004 T_RFC, 280, REF-to-next-command spacing in cycles.
REQ-005 MAX_PEND, 8, maximum postponed refreshes.
REQ-006 CK_t  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-007 reset_n  in  1  asynchronous reset, active low.
REQ-008 clear_refresh  in  1  high clears interval counter and pending count.
REQ-009 refresh_go  in  1  controller is in its refresh state; start sequence.
REQ-010 refresh_almost  out  1  refresh due soon or overdue.
REQ-011 refresh_done  out  1  one-cycle pulse: sequence complete, all banks precharged.
REQ-012 refresh_active  out  1  high in every state except RF_IDLE.
REQ-013 refresh_overflow  out  1  sticky: more than MAX_PEND refreshes postponed.
REQ-014 cs_n, act_n, ras_n, cas_n, we_n, a10  out  1 each  registered DDR command bits.

Function
REQ-015 The block SHALL use states RF_IDLE, RF_PRE, RF_TRP, RF_REF, RF_TRFC and RF_DONE.
REQ-016 interval_cnt SHALL increment every cycle and wrap from T_REFI-1 to 0; each wrap increments pend_cnt.
REQ-017 pend_cnt SHALL saturate at MAX_PEND; a wrap at MAX_PEND SHALL set refresh_overflow, which only reset_n clears.
REQ-018 clear_refresh=1 SHALL zero interval_cnt and pend_cnt next edge, with priority over increment and wrap, and SHALL not affect the sequence FSM.
REQ-019 refresh_almost SHALL be registered and equal (pend_cnt>0) or (interval_cnt >= T_REFI-T_ALMOST), evaluated on next-state counter values.
REQ-020 RF_IDLE: refresh_go=1 at an edge SHALL move to RF_PRE; refresh_go is ignored in all other states.
REQ-021 RF_PRE (1 cycle) SHALL drive PREA: cs_n=0 act_n=1 ras_n=0 cas_n=1 we_n=0 a10=1, then go to RF_TRP.
REQ-022 RF_TRP SHALL hold deselect for T_RP-1 cycles, so REF is driven exactly T_RP cycles after PREA.
REQ-023 RF_REF (1 cycle) SHALL drive REF: cs_n=0 act_n=1 ras_n=0 cas_n=0 we_n=1 a10=0, then go to RF_TRFC.
REQ-024 On REF, pend_cnt>0 SHALL decrement by one; pend_cnt=0 (pulled-in refresh) SHALL reset interval_cnt to 0.
REQ-025 If a wrap coincides with a REF decrement, pend_cnt SHALL stay unchanged and refresh_overflow SHALL not set.
REQ-026 RF_TRFC SHALL hold deselect for T_RFC-1 cycles, then go to RF_REF if pend_cnt>0, else to RF_DONE.
REQ-027 Back-to-back REFs SHALL be spaced exactly T_RFC cycles with no intervening PREA.
REQ-028 RF_DONE (1 cycle) SHALL assert refresh_done and return to RF_IDLE; refresh_done is low in all other cycles.
REQ-029 Outside RF_PRE/RF_REF, outputs SHALL be deselect: cs_n=1 act_n=1 ras_n=1 cas_n=1 we_n=1 a10=0.
REQ-030 The wait counter SHALL be T_RFC-wide and reloaded on entry to RF_TRP and RF_TRFC.

Reset
REQ-031 reset_n=0 SHALL immediately force RF_IDLE, zero all counters, and drive refresh_almost, refresh_done, refresh_active and refresh_overflow to 0 with command outputs at deselect.
REQ-032 Reset mid-sequence SHALL abort with no further command; after release, the block SHALL start counting from interval_cnt=0.

Verification (T_REFI=100, T_ALMOST=10, T_RP=4, T_RFC=20, MAX_PEND=8)
REQ-033 Release reset, clear_refresh=0 -> refresh_almost rises when interval_cnt reaches 90; pend_cnt=1 at cycle 100.
REQ-034 refresh_go at interval_cnt=92, pend_cnt=0 -> PREA at k, REF at k+4, refresh_done at k+24; interval_cnt=0 after REF.
REQ-035 Three wraps, then refresh_go -> one PREA, REFs at k+4, k+24, k+44, refresh_done at k+64, pend_cnt=0, refresh_almost low.
REQ-036 Nine wraps with no refresh_go -> pend_cnt=8, refresh_overflow=1 from ninth wrap until reset.
REQ-037 reset_n low during RF_TRFC -> deselect and refresh_active=0 without a clock edge; no refresh_done.
REQ-038 Wrap on same edge as REF with pend_cnt=2 -> pend_cnt stays 2, second REF follows 20 cycles later.
